output_port_alloc: RTL and testbench
====================================

// Module: output_port_alloc
// PURPOSE
//  Per-output-port allocator placed directly downstream of the input virtual channels.
//  Performs OVC allocation: grants a free downstream VC to an input VC that is waiting with a head or single flit.
//  Performs switch allocation: picks one ACTIVE input VC per cycle, drives its credit/consume (C) line, and registers the chosen flit.
//  Tracks downstream credits per OVC. One instance per router output port.
// PARAMETERS
//  NUM_IN    5   number of input VCs that can target this port
//  NUM_OVC   2   downstream VCs on this output port
//  VC_SIZE   8   downstream buffer depth per OVC (initial credits)
//  FLIT_SIZE pkg flit width; HEADER_LEN, HEAD_FLIT, TAIL_FLIT, SINGLE_FLIT from shared package
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  reset, synchronous, active-high
//  ovc_req       in   NUM_IN             input VC i waits for an OVC on this port
//  ovc_grant     out  NUM_IN             one-hot/zero, combinational; OVC assigned this cycle
//  ovc_grant_id  out  $clog2(NUM_OVC)    OVC index given with ovc_grant
//  flit_valid_in in   NUM_IN             input VC i has a flit for this port (ACTIVE, non-empty)
//  flit_in       in   NUM_IN*FLIT_SIZE   flit of input VC i, slice i
//  credit_ok     out  NUM_IN             one-hot/zero, combinational; input i may consume its flit now
//  credit_ret    in   NUM_OVC            downstream freed one slot of OVC k (1 credit per cycle)
//  flit_out      out  FLIT_SIZE          registered switched flit
//  valid_out     out  1                  flit_out valid
//  ovc_out       out  $clog2(NUM_OVC)    OVC that flit_out is written into
//  ovc_busy      out  NUM_OVC            OVC k currently owned by a packet
//  credit_err    out  1                  sticky; credit_ret seen while credits == VC_SIZE
// BEHAVIOUR
//  Reset values:
//   - credits[k] = VC_SIZE; busy = 0; owner = 0; both RR pointers = 0.
//   - valid_out = 0; flit_out = 0; ovc_out = 0; credit_err = 0.
//   - ovc_grant and credit_ok are 0 while rst is high.
//  OVC allocation (combinational on registered state):
//   - Eligible inputs are those with ovc_req set that own no OVC.
//   - If any OVC is free, the round-robin winner is granted the lowest-index free OVC.
//   - At the clock edge the OVC sets busy, owner = winner, and the pointer moves to winner+1 mod NUM_IN.
//   - At most one grant per cycle; with no free OVC, nothing is granted and the pointer holds.
//  Switch allocation (combinational):
//   - Input i is eligible when flit_valid_in[i] is set, i owns OVC k, and credits[k] > 0.
//   - The round-robin winner w gets credit_ok[w] = 1.
//   - At the edge: flit_out <= flit_in[w]; valid_out <= 1; ovc_out <= k; credits[k] -= 1; pointer <= w+1.
//   - If the header of flit_in[w] is TAIL_FLIT or SINGLE_FLIT, busy[k] clears at the same edge (packet released).
//   - With no winner, valid_out <= 0 and flit_out holds. Latency is 1 cycle from credit_ok to valid_out.
//  Credit arithmetic:
//   - Counter width is $clog2(VC_SIZE+1).
//   - Consume and credit_ret on the same OVC in the same cycle leave the count unchanged.
//   - credit_ret at full count saturates (no wrap) and sets credit_err.
//  Boundaries:
//   - An OVC released this cycle can be reallocated from the next cycle only.
//   - An OVC granted this cycle can carry its first flit from the next cycle.
//   - A request with credits == 0 gets no credit_ok; the input stalls holding its flit.
//   - rst mid-packet: all ownership and credits return to reset values immediately. Upstream VCs are reset by the same rst.
//   - ovc_grant and credit_ok are never both set for the same input in the same cycle.
// STRUCTURE
//  - Shared package: flit header constants, FLIT_SIZE, HEADER_LEN, VC_SIZE, plus a new typedef ovc_state_t {busy, owner, credits}.
//  - Sub-module rr_arbiter #(N): req[N], ptr in, one-hot gnt, winner index, any. Instantiated twice (OVC and switch).
//  - Owner-to-input reverse map is derived combinationally in the top.
// TESTING
//  1 After reset: ovc_req=5'b00001 -> ovc_grant=5'b00001, id=0; next cycle ovc_busy=2'b01.
//  2 Inputs 0..2 all request with NUM_OVC=2 -> grants to 0 then 1; input 2 waits until a tail from input 0 releases OVC0, then gets OVC0 one cycle later.
//  3 Input 0 owns OVC0 and sends 8 body flits without credit_ret -> credit_ok drops on the 9th cycle; one credit_ret restores credit_ok the cycle after.
//  4 Inputs 0 and 1 each own an OVC, both flit_valid_in held -> credit_ok alternates 01,10,01; valid_out follows one cycle later with matching ovc_out.
//  5 Same cycle consume and credit_ret on OVC1 -> credits unchanged; credit_ret at credits==8 -> stays 8 and credit_err=1.
//  6 rst asserted mid-packet -> next cycle ovc_busy=0, credits=8, valid_out=0, credit_err=0.

Source files
------------

// File: rtl/output_port_alloc_pkg.sv
// rtl/output_port_alloc_pkg.sv - flit header constants, sizes and per-OVC state type
package output_port_alloc_pkg;

    localparam int FLIT_SIZE  = 16;
    localparam int HEADER_LEN = 2;

    localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00;
    localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b01;
    localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
    localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

    localparam int VC_SIZE  = 8;
    localparam int MAX_IN   = 8;
    localparam int OWNER_W  = $clog2(MAX_IN);
    localparam int CREDIT_W = $clog2(VC_SIZE + 1);

    typedef struct packed {
        logic                busy;
        logic [OWNER_W-1:0]  owner;
        logic [CREDIT_W-1:0] credits;
    } ovc_state_t;

    // Header sits in the top HEADER_LEN bits of every flit.
    function automatic logic releases_ovc(input logic [FLIT_SIZE-1:0] flit);
        logic [HEADER_LEN-1:0] hdr;
        hdr = flit[FLIT_SIZE-1 -: HEADER_LEN];
        return (hdr == TAIL_FLIT) || (hdr == SINGLE_FLIT);
    endfunction

endpackage

// File: rtl/output_port_alloc_rr_arbiter.sv
// rtl/output_port_alloc_rr_arbiter.sv - round-robin arbiter, search starts at ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < N; j++) begin
            int c;
            c = (int'(ptr) + j) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/output_port_alloc.sv
// rtl/output_port_alloc.sv - per-output-port OVC allocator, switch allocator and credit tracker
module output_port_alloc #(
    parameter int NUM_IN  = 5,
    parameter int NUM_OVC = 2,
    parameter int VC_SIZE = output_port_alloc_pkg::VC_SIZE,
    parameter int IN_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter int OVC_W   = (NUM_OVC > 1) ? $clog2(NUM_OVC) : 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [NUM_IN-1:0]                                ovc_req,
    output logic [NUM_IN-1:0]                                ovc_grant,
    output logic [OVC_W-1:0]                                 ovc_grant_id,
    input  logic [NUM_IN-1:0]                                flit_valid_in,
    input  logic [NUM_IN*output_port_alloc_pkg::FLIT_SIZE-1:0] flit_in,
    output logic [NUM_IN-1:0]                                credit_ok,
    input  logic [NUM_OVC-1:0]                               credit_ret,
    output logic [output_port_alloc_pkg::FLIT_SIZE-1:0]      flit_out,
    output logic                                             valid_out,
    output logic [OVC_W-1:0]                                 ovc_out,
    output logic [NUM_OVC-1:0]                               ovc_busy,
    output logic                                             credit_err
);
    import output_port_alloc_pkg::*;

    // NUM_IN must not exceed MAX_IN and VC_SIZE must fit in CREDIT_W.
    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(VC_SIZE);

    ovc_state_t [NUM_OVC-1:0] ovc_q, ovc_d;
    logic [IN_W-1:0]          optr_q, optr_d;
    logic [IN_W-1:0]          sptr_q, sptr_d;
    logic                     valid_q, valid_d;
    logic [FLIT_SIZE-1:0]     flit_q, flit_d;
    logic [OVC_W-1:0]         ovc_out_q, ovc_out_d;
    logic                     err_q, err_d;

    logic [NUM_IN-1:0]             owns;
    logic [NUM_IN-1:0][OVC_W-1:0]  own_ovc;
    logic                          any_free;
    logic [OVC_W-1:0]              free_id;
    logic [NUM_IN-1:0]             o_req, o_gnt, s_req, s_gnt;
    logic [IN_W-1:0]               o_idx, s_idx;
    logic                          o_any, s_any;
    logic [FLIT_SIZE-1:0]          win_flit;
    logic [OVC_W-1:0]              win_ovc;

    function automatic logic [IN_W-1:0] next_ptr(input logic [IN_W-1:0] idx);
        return (int'(idx) == NUM_IN - 1) ? '0 : idx + 1'b1;
    endfunction

    // Reverse map: which OVC (if any) each input currently owns.
    always_comb begin
        owns    = '0;
        own_ovc = '0;
        for (int k = 0; k < NUM_OVC; k++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (ovc_q[k].busy && ovc_q[k].owner == OWNER_W'(i)) begin
                    owns[i]    = 1'b1;
                    own_ovc[i] = OVC_W'(k);
                end
            end
        end
    end

    // Descending scan so the lowest free index is the one left standing.
    always_comb begin
        any_free = 1'b0;
        free_id  = '0;
        for (int k = NUM_OVC - 1; k >= 0; k--) begin
            if (!ovc_q[k].busy) begin
                any_free = 1'b1;
                free_id  = OVC_W'(k);
            end
        end
    end

    always_comb begin
        o_req = ovc_req & ~owns & {NUM_IN{any_free & ~rst}};
        s_req = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            s_req[i] = flit_valid_in[i] & owns[i] & ~rst &
                       (ovc_q[own_ovc[i]].credits != '0);
        end
    end

    rr_arbiter #(.N(NUM_IN), .IW(IN_W)) u_ovc_arb (
        .req (o_req),
        .ptr (optr_q),
        .gnt (o_gnt),
        .idx (o_idx),
        .any (o_any)
    );

    rr_arbiter #(.N(NUM_IN), .IW(IN_W)) u_sw_arb (
        .req (s_req),
        .ptr (sptr_q),
        .gnt (s_gnt),
        .idx (s_idx),
        .any (s_any)
    );

    assign win_flit = flit_in[int'(s_idx)*FLIT_SIZE +: FLIT_SIZE];
    assign win_ovc  = own_ovc[s_idx];

    always_comb begin
        ovc_d     = ovc_q;
        optr_d    = optr_q;
        sptr_d    = sptr_q;
        valid_d   = 1'b0;
        flit_d    = flit_q;
        ovc_out_d = ovc_out_q;
        err_d     = err_q;

        if (o_any) begin
            ovc_d[free_id].busy  = 1'b1;
            ovc_d[free_id].owner = OWNER_W'(o_idx);
            optr_d               = next_ptr(o_idx);
        end

        // A granted OVC is free this cycle, so it never collides with the consumed one.
        for (int k = 0; k < NUM_OVC; k++) begin
            logic consume;
            consume = s_any && (win_ovc == OVC_W'(k));
            if (consume && !credit_ret[k]) begin
                ovc_d[k].credits = ovc_q[k].credits - 1'b1;
            end else if (credit_ret[k] && !consume) begin
                if (ovc_q[k].credits == FULL) begin
                    err_d = 1'b1;
                end else begin
                    ovc_d[k].credits = ovc_q[k].credits + 1'b1;
                end
            end
            if (consume && releases_ovc(win_flit)) begin
                ovc_d[k].busy = 1'b0;
            end
        end

        if (s_any) begin
            valid_d   = 1'b1;
            flit_d    = win_flit;
            ovc_out_d = win_ovc;
            sptr_d    = next_ptr(s_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_OVC; k++) begin
                ovc_q[k].busy    <= 1'b0;
                ovc_q[k].owner   <= '0;
                ovc_q[k].credits <= FULL;
            end
            optr_q    <= '0;
            sptr_q    <= '0;
            valid_q   <= 1'b0;
            flit_q    <= '0;
            ovc_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ovc_q     <= ovc_d;
            optr_q    <= optr_d;
            sptr_q    <= sptr_d;
            valid_q   <= valid_d;
            flit_q    <= flit_d;
            ovc_out_q <= ovc_out_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OVC; k++) begin
            ovc_busy[k] = ovc_q[k].busy;
        end
    end

    assign ovc_grant    = o_gnt;
    assign ovc_grant_id = free_id;
    assign credit_ok    = s_gnt;
    assign flit_out     = flit_q;
    assign valid_out    = valid_q;
    assign ovc_out      = ovc_out_q;
    assign credit_err   = err_q;

endmodule

// File: tb/tb_output_port_alloc.sv
// tb/tb_output_port_alloc.sv - table, directed and randomized checks of output_port_alloc
module tb_output_port_alloc;
    import output_port_alloc_pkg::*;

    localparam int NI = 5;
    localparam int NO = 2;
    localparam int PW = FLIT_SIZE - HEADER_LEN;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NI-1:0]           ovc_req, ovc_grant, flit_valid_in, credit_ok;
    logic [0:0]              ovc_grant_id, ovc_out;
    logic [NI*FLIT_SIZE-1:0] flit_in;
    logic [NO-1:0]           credit_ret, ovc_busy;
    logic [FLIT_SIZE-1:0]    flit_out;
    logic                    valid_out, credit_err;

    output_port_alloc #(.NUM_IN(NI), .NUM_OVC(NO), .VC_SIZE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .ovc_req       (ovc_req),
        .ovc_grant     (ovc_grant),
        .ovc_grant_id  (ovc_grant_id),
        .flit_valid_in (flit_valid_in),
        .flit_in       (flit_in),
        .credit_ok     (credit_ok),
        .credit_ret    (credit_ret),
        .flit_out      (flit_out),
        .valid_out     (valid_out),
        .ovc_out       (ovc_out),
        .ovc_busy      (ovc_busy),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [FLIT_SIZE-1:0] cur_flit [NI];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NI-1:0] req, input logic [NI-1:0] fv,
                         input logic [NI-1:0] tail, input logic [NO-1:0] ret);
        ovc_req       = req;
        flit_valid_in = fv;
        credit_ret    = ret;
        for (int i = 0; i < NI; i++) begin
            cur_flit[i] = {tail[i] ? TAIL_FLIT : BODY_FLIT, PW'($urandom)};
            flit_in[i*FLIT_SIZE +: FLIT_SIZE] = cur_flit[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NI-1:0] req, fv, tail;
        logic [NO-1:0] ret;
        logic [NI-1:0] e_grant;
        logic          e_gid;
        logic [NI-1:0] e_cok;
        logic [NO-1:0] e_busy;
        logic          e_valid;
        logic          e_ovc;
    } vec_t;

    vec_t tbl [10];

    // Reference model state, kept as plain integers per OVC.
    int   m_busy [NO];
    int   m_owner[NO];
    int   m_cred [NO];
    int   m_optr, m_sptr, m_ovc;
    logic m_valid, m_err;
    logic [FLIT_SIZE-1:0] m_flit;

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_cred[k] = 8;
        end
        m_optr = 0; m_sptr = 0; m_ovc = 0;
        m_valid = 1'b0; m_err = 1'b0; m_flit = '0;
    endtask

    initial begin
        logic [NI-1:0] req, fv, tailm, e_grant, e_cok;
        logic [NO-1:0] ret, e_busy;
        int own[NI];
        int free_k, gw, sw;
        logic r;

        tbl[0] = '{5'b00001, 5'b00000, 5'b00000, 2'b00, 5'b00001, 1'b0, 5'b00000, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{5'b00110, 5'b00000, 5'b00000, 2'b00, 5'b00010, 1'b1, 5'b00000, 2'b01, 1'b0, 1'b0};
        tbl[2] = '{5'b00100, 5'b00011, 5'b00000, 2'b00, 5'b00000, 1'b0, 5'b00001, 2'b11, 1'b0, 1'b0};
        tbl[3] = '{5'b00100, 5'b00011, 5'b00001, 2'b00, 5'b00000, 1'b0, 5'b00010, 2'b11, 1'b1, 1'b0};
        tbl[4] = '{5'b00100, 5'b00001, 5'b00001, 2'b00, 5'b00000, 1'b0, 5'b00001, 2'b11, 1'b1, 1'b1};
        tbl[5] = '{5'b00100, 5'b00000, 5'b00000, 2'b00, 5'b00100, 1'b0, 5'b00000, 2'b10, 1'b1, 1'b0};
        tbl[6] = '{5'b00000, 5'b00110, 5'b00000, 2'b00, 5'b00000, 1'b0, 5'b00010, 2'b11, 1'b0, 1'b0};
        tbl[7] = '{5'b00000, 5'b00110, 5'b00000, 2'b00, 5'b00000, 1'b0, 5'b00100, 2'b11, 1'b1, 1'b1};
        tbl[8] = '{5'b00000, 5'b00110, 5'b00000, 2'b00, 5'b00000, 1'b0, 5'b00010, 2'b11, 1'b1, 1'b0};
        tbl[9] = '{5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b0, 5'b00000, 2'b11, 1'b1, 1'b1};

        #1;
        do_reset();
        @(negedge clk);
        check("reset_busy", ovc_busy, 2'b00);
        check("reset_valid", valid_out, 1'b0);
        check("reset_flit", flit_out, 16'h0);
        check("reset_ovc_out", ovc_out, 1'b0);
        check("reset_err", credit_err, 1'b0);
        tick();

        // Allocation order, release/reallocate and alternating switch grants.
        do_reset();
        for (int s = 0; s < 10; s++) begin
            drive(tbl[s].req, tbl[s].fv, tbl[s].tail, tbl[s].ret);
            @(negedge clk);
            check($sformatf("tbl%0d_grant", s), ovc_grant, tbl[s].e_grant);
            if (tbl[s].e_grant != '0) check($sformatf("tbl%0d_gid", s), ovc_grant_id, tbl[s].e_gid);
            check($sformatf("tbl%0d_cok", s), credit_ok, tbl[s].e_cok);
            check($sformatf("tbl%0d_busy", s), ovc_busy, tbl[s].e_busy);
            check($sformatf("tbl%0d_valid", s), valid_out, tbl[s].e_valid);
            if (tbl[s].e_valid) check($sformatf("tbl%0d_ovc_out", s), ovc_out, tbl[s].e_ovc);
            tick();
        end

        // Credit exhaustion after 8 flits, one returned credit re-enables.
        do_reset();
        drive(5'b00001, '0, '0, '0);
        tick();
        for (int c = 0; c < 10; c++) begin
            drive('0, 5'b00001, '0, (c == 8) ? 2'b01 : 2'b00);
            @(negedge clk);
            check($sformatf("exhaust_cok%0d", c), credit_ok, (c == 8) ? 5'b00000 : 5'b00001);
            if (c == 1) check("exhaust_ovc_out", {valid_out, ovc_out}, 2'b10);
            tick();
        end

        // Same-cycle consume and return on OVC1, then a return at full count.
        do_reset();
        drive(5'b00011, '0, '0, '0);
        tick();
        drive(5'b00010, '0, '0, '0);
        @(negedge clk);
        check("same_grant1", {ovc_grant, ovc_grant_id}, {5'b00010, 1'b1});
        tick();
        drive('0, 5'b00010, '0, 2'b10);
        @(negedge clk);
        check("same_cok", credit_ok, 5'b00010);
        tick();
        drive('0, '0, '0, 2'b10);
        @(negedge clk);
        check("same_err_before", credit_err, 1'b0);
        tick();
        drive('0, '0, '0, '0);
        @(negedge clk);
        check("same_err_after", credit_err, 1'b1);
        tick();

        // Reset in the middle of a packet.
        do_reset();
        drive(5'b00001, '0, '0, 2'b10);
        tick();
        drive('0, 5'b00001, '0, '0);
        tick();
        rst = 1'b1;
        drive('1, '1, '0, '0);
        @(negedge clk);
        check("midrst_pre_state", {ovc_busy, valid_out, credit_err}, {2'b01, 1'b1, 1'b1});
        check("midrst_grant_gated", ovc_grant, 5'b00000);
        check("midrst_cok_gated", credit_ok, 5'b00000);
        tick();
        rst = 1'b0;
        drive('0, '0, '0, 2'b01);
        @(negedge clk);
        check("midrst_post_state", {ovc_busy, valid_out, credit_err}, {2'b00, 1'b0, 1'b0});
        tick();
        drive('0, '0, '0, '0);
        @(negedge clk);
        check("midrst_credits_full", credit_err, 1'b1);
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            r = ($urandom_range(0, 79) == 0);
            req = NI'($urandom);
            fv  = NI'($urandom);
            for (int i = 0; i < NI; i++) tailm[i] = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NO; k++) ret[k] = ($urandom_range(0, 5) == 0);
            rst = r;
            drive(req, fv, tailm, ret);

            for (int i = 0; i < NI; i++) begin
                own[i] = -1;
                for (int k = 0; k < NO; k++) if (m_busy[k] != 0 && m_owner[k] == i) own[i] = k;
            end
            free_k = -1;
            for (int k = NO - 1; k >= 0; k--) if (m_busy[k] == 0) free_k = k;
            gw = -1;
            sw = -1;
            for (int j = 0; j < NI; j++) begin
                int i;
                i = (m_optr + j) % NI;
                if (!r && free_k >= 0 && gw < 0 && req[i] && own[i] < 0) gw = i;
                i = (m_sptr + j) % NI;
                if (!r && sw < 0 && fv[i] && own[i] >= 0) begin
                    if (m_cred[own[i]] > 0) sw = i;
                end
            end
            e_grant = '0;
            e_cok   = '0;
            if (gw >= 0) e_grant[gw] = 1'b1;
            if (sw >= 0) e_cok[sw] = 1'b1;
            for (int k = 0; k < NO; k++) e_busy[k] = (m_busy[k] != 0);

            @(negedge clk);
            check($sformatf("rnd%0d_grant", c), ovc_grant, e_grant);
            if (gw >= 0) check($sformatf("rnd%0d_gid", c), ovc_grant_id, free_k);
            check($sformatf("rnd%0d_cok", c), credit_ok, e_cok);
            check($sformatf("rnd%0d_busy", c), ovc_busy, e_busy);
            check($sformatf("rnd%0d_valid", c), valid_out, m_valid);
            check($sformatf("rnd%0d_flit", c), flit_out, m_flit);
            if (m_valid) check($sformatf("rnd%0d_ovc_out", c), ovc_out, m_ovc);
            check($sformatf("rnd%0d_err", c), credit_err, m_err);
            tick();

            if (r) begin
                model_reset();
            end else begin
                for (int k = 0; k < NO; k++) begin
                    logic consume;
                    consume = (sw >= 0) && (own[sw] == k);
                    if (consume && !ret[k]) m_cred[k]--;
                    else if (ret[k] && !consume) begin
                        if (m_cred[k] == 8) m_err = 1'b1;
                        else m_cred[k]++;
                    end
                    if (consume && tailm[sw]) m_busy[k] = 0;
                end
                if (gw >= 0) begin
                    m_busy[free_k]  = 1;
                    m_owner[free_k] = gw;
                    m_optr = (gw + 1) % NI;
                end
                m_valid = (sw >= 0);
                if (sw >= 0) begin
                    m_flit = cur_flit[sw];
                    m_ovc  = own[sw];
                    m_sptr = (sw + 1) % NI;
                end
            end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
